// File: rtl/sha256_msg_scheduler.sv
// rtl/sha256_msg_scheduler.sv - SHA-256 message schedule generator, 16 words in, W0..W(ROUNDS-1) out
// Optional SHA256_KROM_EN adds the k_data port carrying the round constant Kt beside each Wt.
module sha256_msg_scheduler #(
  parameter int ROUNDS = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        blk_valid,
  output logic        blk_ready,
  input  logic [31:0] blk_word,
  output logic        w_valid,
  input  logic        w_ready,
  output logic [31:0] w_data,
  output logic [5:0]  w_idx,
  output logic        w_last,
  output logic        busy
`ifdef SHA256_KROM_EN
  ,
  output logic [31:0] k_data
`endif
);

  typedef enum logic {LOAD, EMIT} state_t;

  localparam logic [5:0] LAST_IDX = 6'(ROUNDS - 1);

  state_t      state, state_nxt;
  logic        armed;
  logic [3:0]  load_cnt;
  logic [5:0]  emit_cnt;
  logic [31:0] w [16];
  logic [31:0] w_new;
  logic        blk_accept;
  logic        w_fire;

  function automatic logic [31:0] sig0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction

  function automatic logic [31:0] sig1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction

  // Window holds W[t..t+15]; the next word beyond the window is W[t+16].
  assign w_new = sig1(w[14]) + w[9] + sig0(w[1]) + w[0];

  always_comb begin
    state_nxt = state;
    blk_ready = 1'b0;
    w_valid   = 1'b0;
    case (state)
      LOAD: begin
        // armed keeps blk_ready low until the first edge after reset release
        blk_ready = armed;
        if (blk_valid && armed && load_cnt == 4'd15)
          state_nxt = EMIT;
      end
      EMIT: begin
        w_valid = 1'b1;
        if (w_ready && emit_cnt == LAST_IDX)
          state_nxt = LOAD;
      end
      default: state_nxt = LOAD;
    endcase
  end

  assign blk_accept = blk_valid && blk_ready;
  assign w_fire     = w_valid && w_ready;
  assign w_last     = (state == EMIT) && (emit_cnt == LAST_IDX);
  assign w_data     = (state == EMIT) ? w[0] : 32'd0;
  assign w_idx      = emit_cnt;
  assign busy       = (state == EMIT) || (load_cnt != 4'd0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= LOAD;
      armed    <= 1'b0;
      load_cnt <= 4'd0;
      emit_cnt <= 6'd0;
      for (int i = 0; i < 16; i++) w[i] <= 32'd0;
    end else begin
      state <= state_nxt;
      armed <= 1'b1;
      if (blk_accept) begin
        w[load_cnt] <= blk_word;
        load_cnt    <= load_cnt + 4'd1;
      end
      if (w_fire) begin
        for (int i = 0; i < 15; i++) w[i] <= w[i+1];
        w[15]    <= w_new;
        emit_cnt <= w_last ? 6'd0 : emit_cnt + 6'd1;
      end
    end
  end

`ifdef SHA256_KROM_EN
  localparam logic [31:0] KROM [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  assign k_data = (state == EMIT) ? KROM[emit_cnt] : 32'd0;
`endif

endmodule
